// File: rtl/cruise_pkg.sv
// rtl/cruise_pkg.sv - shared cruise-loop types and defaults
package cruise_pkg;

  localparam int SPEED_W           = 8;
  localparam int MAX_SPEED_DEFAULT = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_COAST = 2'd2,
    ST_BRAKE = 2'd3
  } act_state_t;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running 0..TICK_DIV-1 counter with terminal-count tick
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/speed_actuator.sv
// rtl/speed_actuator.sv - rate-limited speed plant; optional SPEED_ACT_JERK_LIMIT_EN ramps the throttle step
module speed_actuator
  import cruise_pkg::*;
#(
  parameter int SPEED_W    = cruise_pkg::SPEED_W,
  parameter int MAX_SPEED  = cruise_pkg::MAX_SPEED_DEFAULT,
  parameter int TICK_DIV   = 4,
  parameter int BRAKE_STEP = 4,
  parameter int COAST_STEP = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tormoz,
  input  logic [2:0]         pashesh,
  input  logic               load,
  input  logic [SPEED_W-1:0] load_speed,
  output logic [SPEED_W-1:0] vfelinew,
  output logic [1:0]         act_state,
  output logic               tick,
  output logic               at_max,
  output logic               stopped
);

  localparam logic [SPEED_W:0] MAX_X   = MAX_SPEED[SPEED_W:0];
  localparam logic [SPEED_W:0] BRAKE_X = BRAKE_STEP[SPEED_W:0];
  localparam logic [SPEED_W:0] COAST_X = COAST_STEP[SPEED_W:0];

  logic [SPEED_W-1:0] speed;
  act_state_t         state;
  logic               tick_i;
  logic [2:0]         step;
  logic [SPEED_W:0]   sum;
  logic [SPEED_W-1:0] next_speed;
  logic [SPEED_W-1:0] load_val;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .clear (load),
    .tick  (tick_i)
  );

`ifdef SPEED_ACT_JERK_LIMIT_EN
  logic [2:0] step_reg;

  // Step climbs one unit per tick toward the throttle, but follows it down at once.
  always_comb begin
    step = (pashesh <= step_reg) ? pashesh : step_reg + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset || load || state != ST_ACCEL) begin
      step_reg <= '0;
    end else if (tick_i) begin
      step_reg <= step;
    end else if (pashesh < step_reg) begin
      step_reg <= pashesh;
    end
  end
`else
  assign step = pashesh;
`endif

  assign sum      = {1'b0, speed} + {{(SPEED_W-2){1'b0}}, step};
  assign load_val = ({1'b0, load_speed} > MAX_X) ? MAX_X[SPEED_W-1:0] : load_speed;

  always_comb begin
    next_speed = speed;
    case (state)
      ST_ACCEL: next_speed = (sum > MAX_X) ? MAX_X[SPEED_W-1:0] : sum[SPEED_W-1:0];
      ST_BRAKE: next_speed = ({1'b0, speed} > BRAKE_X) ? speed - BRAKE_X[SPEED_W-1:0] : '0;
      ST_COAST: next_speed = ({1'b0, speed} > COAST_X) ? speed - COAST_X[SPEED_W-1:0] : '0;
      default:  next_speed = speed;
    endcase
  end

  // Speed updates use the state already registered, so inputs act one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      speed <= '0;
      state <= ST_IDLE;
    end else if (load) begin
      speed <= load_val;
    end else begin
      if (tick_i) begin
        speed <= next_speed;
      end
      if (tormoz) begin
        state <= ST_BRAKE;
      end else if (pashesh != 3'd0) begin
        state <= ST_ACCEL;
      end else if (speed != '0) begin
        state <= ST_COAST;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign vfelinew  = speed;
  assign act_state = state;
  assign tick      = tick_i;
  assign at_max    = (speed == MAX_X[SPEED_W-1:0]);
  assign stopped   = (speed == '0);

endmodule
